// File: rtl/gf180mcu_addh_serial_seq.sv
`default_nettype none
// ============================================================================
// Module   : gf180mcu_addh_serial_seq
// Brief    : Two-requester, round-robin bit-serial adder built on one
//            half-adder pair. Optional macro GF180_ADDH_SEQ_SAT_EN enables
//            unsigned saturation of the sum.
// Revision : 1.0  initial release
// ============================================================================
module gf180mcu_addh_serial_seq #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  output logic             BUSY,
  output logic             VALID,
  output logic             ID,
  output logic [WIDTH-1:0] S,
  output logic             CO
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_s;
  logic [CW-1:0]    r_count;
  logic             r_carry;
  logic             r_co;
  logic             r_valid;
  logic             r_id;
  logic             r_cur_id;
  logic             r_rr_last;

  logic             w_any_req;
  logic             w_winner;
  logic             w_last_bit;
  logic             w_p;
  logic             w_g;
  logic             w_s;
  logic             w_c2;

  // Sole requester wins; on a tie the one not served last time wins.
  assign w_any_req  = REQ0 | REQ1;
  assign w_winner   = (REQ0 & REQ1) ? ~r_rr_last : REQ1;
  assign w_last_bit = (r_count == CW'(WIDTH - 1));

  // Two half adders chained into a full adder on the current LSBs.
  assign w_p  = r_a[0] ^ r_b[0];
  assign w_g  = r_a[0] & r_b[0];
  assign w_s  = w_p ^ r_carry;
  assign w_c2 = w_p & r_carry;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_any_req) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_last_bit) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_a       <= '0;
      r_b       <= '0;
      r_sum     <= '0;
      r_s       <= '0;
      r_count   <= '0;
      r_carry   <= 1'b0;
      r_co      <= 1'b0;
      r_valid   <= 1'b0;
      r_id      <= 1'b0;
      r_cur_id  <= 1'b0;
      r_rr_last <= 1'b1;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_a       <= w_winner ? A1 : A0;
            r_b       <= w_winner ? B1 : B0;
            r_cur_id  <= w_winner;
            r_rr_last <= w_winner;
            r_carry   <= 1'b0;
            r_count   <= '0;
          end
        end
        ST_SHIFT: begin
          r_carry <= w_g | w_c2;
          r_sum   <= {w_s, r_sum[WIDTH-1:1]};
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_count <= r_count + CW'(1);
        end
        ST_DONE: begin
`ifdef GF180_ADDH_SEQ_SAT_EN
          r_s <= r_carry ? {WIDTH{1'b1}} : r_sum;
`else
          r_s <= r_sum;
`endif
          r_co    <= r_carry;
          r_id    <= r_cur_id;
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign BUSY  = (r_state == ST_SHIFT) || (r_state == ST_DONE);
  assign VALID = r_valid;
  assign ID    = r_id;
  assign S     = r_s;
  assign CO    = r_co;

endmodule
`default_nettype wire
